// File: rtl/ship_mover.sv
// ship_mover: tick-paced ship position FSM with a slow-to-fast speed ramp.
// Edge rule: define SHIP_WRAP_EN for wrap-around, else positions clamp.
module ship_mover #(
   parameter int TICK_DIV   = 833333,
   parameter int X_MAX      = 640,
   parameter int Y_MAX      = 480,
   parameter int X_START    = 320,
   parameter int Y_START    = 240,
   parameter int STEP_SLOW  = 1,
   parameter int STEP_FAST  = 3,
   parameter int RAMP_TICKS = 8
) (
   input  logic       KB_clk,
   input  logic       reset,
   input  logic [2:0] direction,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic [1:0] heading,
   output logic       moving,
   output logic       move_tick
);

   typedef enum logic {STOP, MOVE} state_t;

   localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);
   localparam logic [10:0] XM = 11'(X_MAX);
   localparam logic [10:0] YM = 11'(Y_MAX);
   localparam logic [10:0] SS = 11'(STEP_SLOW);
   localparam logic [10:0] SF = 11'(STEP_FAST);
   localparam logic [7:0]  RAMP = 8'(RAMP_TICKS);
   localparam logic [9:0]  XS = 10'(X_START);
   localparam logic [9:0]  YS = 10'(Y_START);

   state_t      state_q, state_d;
   logic [2:0]  dir_q;
   logic [19:0] cnt_q;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic [1:0]  hd_q, hd_d;
   logic [7:0]  run_q, run_d;
   logic        mv_q, mv_d;
   logic        mt_q, mt_d;
   logic        tick;
   logic [10:0] step;
   logic [10:0] x11, y11;

   // Bring a signed-looking 11-bit result back into 0..lim-1.
   function automatic logic [9:0] fix(input logic [10:0] v,
                                      input logic neg,
                                      input logic [10:0] lim);
      logic [10:0] r;
`ifdef SHIP_WRAP_EN
      if (neg)           r = v + lim;
      else if (v >= lim) r = v - lim;
      else               r = v;
`else
      if (neg)           r = '0;
      else if (v >= lim) r = lim - 11'd1;
      else               r = v;
`endif
      return r[9:0];
   endfunction

   assign tick = (cnt_q == TICK_LAST);
   assign x11  = {1'b0, x_q};
   assign y11  = {1'b0, y_q};

   // Next-state: FSM, ramp counter, heading and stepped position.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      hd_d    = hd_q;
      run_d   = run_q;
      mv_d    = mv_q;
      mt_d    = 1'b0;
      step    = SS;
      if (tick) begin
         if (dir_q[2]) begin
            state_d = STOP;
            mv_d    = 1'b0;
         end else begin
            state_d = MOVE;
            mv_d    = 1'b1;
            mt_d    = 1'b1;
            hd_d    = dir_q[1:0];
            run_d   = 8'd1;
            if (state_q == MOVE && dir_q[1:0] == hd_q) begin
               if (run_q >= RAMP) begin
                  step  = SF;
                  run_d = run_q;
               end else begin
                  run_d = run_q + 8'd1;
               end
            end
            case (dir_q[1:0])
               2'b00:   x_d = fix(x11 - step, x11 < step, XM);
               2'b01:   x_d = fix(x11 + step, 1'b0, XM);
               2'b10:   y_d = fix(y11 - step, y11 < step, YM);
               default: y_d = fix(y11 + step, 1'b0, YM);
            endcase
         end
      end
   end

   // State registers; reset overrides any update pending on the tick.
   always_ff @(posedge KB_clk) begin
      if (reset) begin
         state_q <= STOP;
         dir_q   <= 3'b100;
         cnt_q   <= '0;
         x_q     <= XS;
         y_q     <= YS;
         hd_q    <= 2'b10;
         run_q   <= '0;
         mv_q    <= 1'b0;
         mt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= direction;
         cnt_q   <= tick ? '0 : cnt_q + 20'd1;
         x_q     <= x_d;
         y_q     <= y_d;
         hd_q    <= hd_d;
         run_q   <= run_d;
         mv_q    <= mv_d;
         mt_q    <= mt_d;
      end
   end

   assign xpos      = x_q;
   assign ypos      = y_q;
   assign heading   = hd_q;
   assign moving    = mv_q;
   assign move_tick = mt_q;

endmodule

// File: tb/tb_ship_mover.sv
// tb_ship_mover: scoreboard bench for ship_mover with TICK_DIV=4.
// Expected states come from a behavioural model pushed per tick.
module tb_ship_mover;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] direction = 3'b100;
   logic [9:0] xpos, ypos;
   logic [1:0] heading;
   logic       moving, move_tick;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] hd;
      logic       mv;
      logic       mt;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   int mx, my, mhd, mrun;
   bit mmv, mmt;

   always #5 clk = ~clk;

   ship_mover #(.TICK_DIV(TD)) dut (
      .KB_clk(clk),
      .reset(reset),
      .direction(direction),
      .xpos(xpos),
      .ypos(ypos),
      .heading(heading),
      .moving(moving),
      .move_tick(move_tick)
   );

   task automatic push_exp();
      exp_t e;
      e.x  = mx[9:0];
      e.y  = my[9:0];
      e.hd = mhd[1:0];
      e.mv = mmv;
      e.mt = mmt;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      mx = 320; my = 240; mhd = 2; mrun = 0;
      mmv = 0; mmt = 0;
      push_exp();
   endtask

   // Called #1 after a posedge; returns #1 after the next tick edge.
   task automatic drive_tick(input logic [2:0] d);
      int st;
      direction = d;
      if (d < 3'd4) begin
         if (mmv && int'(d[1:0]) == mhd) begin
            if (mrun >= 8) st = 3;
            else begin st = 1; mrun++; end
         end else begin
            st = 1; mrun = 1; mhd = int'(d[1:0]);
         end
         mmv = 1; mmt = 1;
         case (d[1:0])
            2'd0: mx -= st;
            2'd1: mx += st;
            2'd2: my -= st;
            default: my += st;
         endcase
`ifdef SHIP_WRAP_EN
         if (mx < 0) mx += 640;
         if (mx >= 640) mx -= 640;
         if (my < 0) my += 480;
         if (my >= 480) my -= 480;
`else
         if (mx < 0) mx = 0;
         if (mx > 639) mx = 639;
         if (my < 0) my = 0;
         if (my > 479) my = 479;
`endif
      end else begin
         mmv = 0; mmt = 0;
      end
      push_exp();
      repeat (TD) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      e = sb.pop_front();
      checks++;
      if ({xpos, ypos, heading, moving, move_tick} !== e) begin
         errors++;
         $display("FAIL reset: got x=%0d y=%0d hd=%0d mv=%0b mt=%0b exp x=%0d y=%0d hd=%0d mv=%0b mt=%0b",
                  xpos, ypos, heading, moving, move_tick, e.x, e.y, e.hd, e.mv, e.mt);
      end
      reset = 1'b0;
   endtask

   task automatic test_right();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive_tick(3'b001);
         e = sb.pop_front();
         checks++;
         if ({xpos, ypos, heading, moving, move_tick} !== e) begin
            errors++;
            $display("FAIL right t%0d: got x=%0d y=%0d hd=%0d mv=%0b mt=%0b exp x=%0d y=%0d hd=%0d mv=%0b mt=%0b",
                     i, xpos, ypos, heading, moving, move_tick, e.x, e.y, e.hd, e.mv, e.mt);
         end
      end
      checks++;
      if (xpos !== 10'd323) begin
         errors++;
         $display("FAIL right_final: got x=%0d exp 323", xpos);
      end
   endtask

   task automatic test_ramp();
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         drive_tick(3'b010);
         e = sb.pop_front();
         checks++;
         if ({xpos, ypos, heading, moving, move_tick} !== e) begin
            errors++;
            $display("FAIL ramp t%0d: got x=%0d y=%0d hd=%0d mv=%0b mt=%0b exp x=%0d y=%0d hd=%0d mv=%0b mt=%0b",
                     i, xpos, ypos, heading, moving, move_tick, e.x, e.y, e.hd, e.mv, e.mt);
         end
      end
      checks++;
      if (ypos !== 10'd226) begin
         errors++;
         $display("FAIL ramp_final: got y=%0d exp 226", ypos);
      end
   endtask

   task automatic test_turn();
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         drive_tick(3'b000);
         e = sb.pop_front();
         checks++;
         if ({xpos, ypos, heading, moving, move_tick} !== e) begin
            errors++;
            $display("FAIL turn t%0d: got x=%0d y=%0d hd=%0d mv=%0b mt=%0b exp x=%0d y=%0d hd=%0d mv=%0b mt=%0b",
                     i, xpos, ypos, heading, moving, move_tick, e.x, e.y, e.hd, e.mv, e.mt);
         end
         if (i == 0) begin
            checks++;
            if (xpos !== 10'd322 || heading !== 2'b00) begin
               errors++;
               $display("FAIL turn_first: got x=%0d hd=%0d exp x=322 hd=0", xpos, heading);
            end
         end
      end
   endtask

   task automatic test_stop();
      exp_t e;
      drive_tick(3'b111);
      e = sb.pop_front();
      checks++;
      if ({xpos, ypos, heading, moving, move_tick} !== e) begin
         errors++;
         $display("FAIL stop: got x=%0d y=%0d hd=%0d mv=%0b mt=%0b exp x=%0d y=%0d hd=%0d mv=%0b mt=%0b",
                  xpos, ypos, heading, moving, move_tick, e.x, e.y, e.hd, e.mv, e.mt);
      end
      checks++;
      if (moving !== 1'b0 || move_tick !== 1'b0) begin
         errors++;
         $display("FAIL stop_flags: got mv=%0b mt=%0b exp 0 0", moving, move_tick);
      end
   endtask

   task automatic test_reset_tick();
      exp_t e;
      direction = 3'b011;
      repeat (TD - 1) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      e = sb.pop_front();
      checks++;
      if ({xpos, ypos, heading, moving, move_tick} !== e) begin
         errors++;
         $display("FAIL reset_tick: got x=%0d y=%0d hd=%0d mv=%0b mt=%0b exp x=%0d y=%0d hd=%0d mv=%0b mt=%0b",
                  xpos, ypos, heading, moving, move_tick, e.x, e.y, e.hd, e.mv, e.mt);
      end
      reset = 1'b0;
   endtask

   task automatic test_edge();
      exp_t e;
      int n;
      n = 0;
      while ((mx != 0 || n == 0) && n < 200) begin
         drive_tick(3'b000);
         n++;
         e = sb.pop_front();
         checks++;
         if ({xpos, ypos, heading, moving, move_tick} !== e) begin
            errors++;
            $display("FAIL edge t%0d: got x=%0d y=%0d hd=%0d mv=%0b mt=%0b exp x=%0d y=%0d hd=%0d mv=%0b mt=%0b",
                     n, xpos, ypos, heading, moving, move_tick, e.x, e.y, e.hd, e.mv, e.mt);
         end
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL edge_reach: got %0d ticks exp < 200", n);
      end
      drive_tick(3'b000);
      e = sb.pop_front();
      checks++;
`ifdef SHIP_WRAP_EN
      if (xpos !== 10'd637 || move_tick !== 1'b1) begin
         errors++;
         $display("FAIL edge_cross: got x=%0d mt=%0b exp x=637 mt=1", xpos, move_tick);
      end
`else
      if (xpos !== 10'd0 || move_tick !== 1'b1) begin
         errors++;
         $display("FAIL edge_cross: got x=%0d mt=%0b exp x=0 mt=1", xpos, move_tick);
      end
`endif
      checks++;
      if ({xpos, ypos, heading, moving, move_tick} !== e) begin
         errors++;
         $display("FAIL edge_model: got x=%0d y=%0d exp x=%0d y=%0d", xpos, ypos, e.x, e.y);
      end
   endtask

   initial begin
      test_reset();
      test_right();
      test_ramp();
      test_turn();
      test_stop();
      test_reset_tick();
      test_edge();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ship_mover.md
SHIP_MOVER -- requirements
Module: ship_mover

Interface
REQ-001 Parameter TICK_DIV, default 833333, clocks per movement tick (60 Hz at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter X_MAX, default 640, screen width in pixels; legal xpos range 0..X_MAX-1.
REQ-003 Parameter Y_MAX, default 480, screen height in pixels; legal ypos range 0..Y_MAX-1.
REQ-004 Parameter X_START, default 320, xpos reset value.
REQ-005 Parameter Y_START, default 240, ypos reset value.
REQ-006 Parameter STEP_SLOW, default 1, pixels per tick before ramp; range 1..X_MAX-1 and 1..Y_MAX-1.
REQ-007 Parameter STEP_FAST, default 3, pixels per tick after ramp; STEP_FAST >= STEP_SLOW, same range limits as STEP_SLOW.
REQ-008 Parameter RAMP_TICKS, default 8, consecutive same-direction ticks before STEP_FAST applies; range 1..255.
REQ-009 KB_clk  input  1  single clock; all state updates on its rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 direction  input  3  keyboard direction code: 000 left, 001 right, 010 up, 011 down, 100 stationary; 101-111 treated as stationary.
REQ-012 xpos  output  10  ship x coordinate, registered.
REQ-013 ypos  output  10  ship y coordinate, registered.
REQ-014 heading  output  2  last non-stationary direction (00 left, 01 right, 10 up, 11 down), registered.
REQ-015 moving  output  1  high while FSM is in MOVE, registered.
REQ-016 move_tick  output  1  one-cycle pulse in the cycle a position update becomes visible.

Function
REQ-017 direction is registered into dir_q every cycle; only dir_q drives movement (1-cycle input latency).
REQ-018 Prescaler counts 0..TICK_DIV-1 and wraps to 0; the tick is the cycle the count equals TICK_DIV-1.
REQ-019 FSM states STOP and MOVE; all transitions occur only on tick.
REQ-020 STOP -> MOVE on tick when dir_q is 000-011; the step is applied on that same tick at STEP_SLOW.
REQ-021 MOVE -> STOP on tick when dir_q is stationary; no position change on that tick.
REQ-022 In MOVE with dir_q equal to heading, the run counter increments, saturating at RAMP_TICKS; step is STEP_FAST once the counter has reached RAMP_TICKS, else STEP_SLOW.
REQ-023 In MOVE with dir_q different from heading and non-stationary, the run counter clears to 1, the step is STEP_SLOW, and heading updates.
REQ-024 Left: xpos decreases by step; right: xpos increases by step; up: ypos decreases by step; down: ypos increases by step.
REQ-025 Edge handling per REQ-034/REQ-035; intermediate arithmetic is 11 bits wide, so no silent 10-bit overflow occurs.
REQ-026 Position, heading, moving, and the run counter update at the tick edge; move_tick is high in the following cycle only when a step was applied.
REQ-027 Direction changes between ticks are ignored; only dir_q at the tick matters.

Reset
REQ-028 While reset is high at a clock edge: xpos=X_START, ypos=Y_START, heading=10, moving=0, move_tick=0, FSM=STOP, prescaler=0, run counter=0, dir_q=100.
REQ-029 Reset mid-operation, including in the tick cycle, overrides any pending update; the first tick after release occurs TICK_DIV cycles after reset deasserts.

Configuration
REQ-030 Macro SHIP_WRAP_EN selects edge behaviour; exactly one edge rule is compiled in.
REQ-031 Without any macro, reset values and FSM behaviour are identical to the build with the macro defined.
REQ-032 Edge rule scope: xpos stays within 0..X_MAX-1 and ypos within 0..Y_MAX-1 in both builds.
REQ-033 Edge rule scope: move_tick pulses on every applied step in both builds, including clamped zero-distance steps.
REQ-034 With SHIP_WRAP_EN defined: a result below 0 adds X_MAX (or Y_MAX); a result at or above the maximum subtracts it.
REQ-035 Without SHIP_WRAP_EN: results saturate at 0 and at X_MAX-1 / Y_MAX-1.

Verification
REQ-036 Setup for all scenarios: TICK_DIV=4, defaults otherwise; reset, hold direction=001 for 3 ticks -> xpos 321,322,323; moving=1; heading=01; move_tick pulses each tick.
REQ-037 Hold 010 for 10 ticks from ypos=240 -> ticks 1-8 step 1, ticks 9-10 step 3; final ypos=226.
REQ-038 Direction change: switch 010 to 000 after ramp -> first left tick step 1; heading=00; run counter restarts.
REQ-039 Left edge: xpos=0, direction=000 -> SHIP_WRAP_EN defined: xpos=639; undefined: xpos=0, move_tick still pulses.
REQ-040 Code 111 on tick while MOVE -> FSM=STOP, moving=0, no move_tick, position unchanged; reset asserted on the tick cycle -> xpos=320, ypos=240 next cycle.
